// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result queues (ALU, LSB) feeding one registered
// common data bus broadcast with round-robin arbitration between sources.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_W      = `ROB_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_data,
    input  logic             alu_set_jump_addr,
    input  logic             lsb_valid,
    output logic             lsb_ready,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_data,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_data,
    output logic             cdb_set_jump_addr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    logic [ROB_W-1:0] alu_rob_q [FIFO_DEPTH];
    logic [31:0]      alu_data_q [FIFO_DEPTH];
    logic             alu_jmp_q [FIFO_DEPTH];
    logic [ROB_W-1:0] lsb_rob_q [FIFO_DEPTH];
    logic [31:0]      lsb_data_q [FIFO_DEPTH];

    logic [PW-1:0] alu_hd_q, alu_hd_d, alu_tl_q, alu_tl_d;
    logic [PW-1:0] lsb_hd_q, lsb_hd_d, lsb_tl_q, lsb_tl_d;
    logic [PW:0]   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
    logic          last_lsb_q, last_lsb_d;
    logic          cdb_valid_q, cdb_valid_d, cdb_jmp_q, cdb_jmp_d;
    logic [ROB_W-1:0] cdb_rob_q, cdb_rob_d;
    logic [31:0]   cdb_data_q, cdb_data_d;
    logic          run, kill, alu_ne, lsb_ne, alu_push, lsb_push, alu_pop, lsb_pop;

    assign alu_ready = alu_cnt_q < FULL;
    assign lsb_ready = lsb_cnt_q < FULL;
    assign run       = rdy_in & ~flush;
    assign kill      = rdy_in & flush;
    assign alu_ne    = |alu_cnt_q;
    assign lsb_ne    = |lsb_cnt_q;
    assign alu_push  = run & alu_valid & alu_ready;
    assign lsb_push  = run & lsb_valid & lsb_ready;
    // last_lsb_q=1 means LSB won last, so ALU wins the next contested cycle
    assign alu_pop   = run & alu_ne & (~lsb_ne | last_lsb_q);
    assign lsb_pop   = run & lsb_ne & (~alu_ne | ~last_lsb_q);

    always_comb begin
        alu_hd_d    = kill ? '0 : alu_hd_q + PW'(alu_pop);
        alu_tl_d    = kill ? '0 : alu_tl_q + PW'(alu_push);
        alu_cnt_d   = kill ? '0 : alu_cnt_q + (PW+1)'(alu_push) - (PW+1)'(alu_pop);
        lsb_hd_d    = kill ? '0 : lsb_hd_q + PW'(lsb_pop);
        lsb_tl_d    = kill ? '0 : lsb_tl_q + PW'(lsb_push);
        lsb_cnt_d   = kill ? '0 : lsb_cnt_q + (PW+1)'(lsb_push) - (PW+1)'(lsb_pop);
        last_lsb_d  = (kill | lsb_pop) ? 1'b1 : alu_pop ? 1'b0 : last_lsb_q;
        cdb_valid_d = rdy_in ? (alu_pop | lsb_pop) : cdb_valid_q;
        cdb_rob_d   = alu_pop ? alu_rob_q[alu_hd_q] : lsb_pop ? lsb_rob_q[lsb_hd_q] : cdb_rob_q;
        cdb_data_d  = alu_pop ? alu_data_q[alu_hd_q] : lsb_pop ? lsb_data_q[lsb_hd_q] : cdb_data_q;
        cdb_jmp_d   = alu_pop ? alu_jmp_q[alu_hd_q] : lsb_pop ? 1'b0 : cdb_jmp_q;
    end

    always_ff @(posedge clk_in) begin
        if (alu_push) begin
            alu_rob_q[alu_tl_q]  <= alu_rob_id;
            alu_data_q[alu_tl_q] <= alu_data;
            alu_jmp_q[alu_tl_q]  <= alu_set_jump_addr;
        end
        if (lsb_push) begin
            lsb_rob_q[lsb_tl_q]  <= lsb_rob_id;
            lsb_data_q[lsb_tl_q] <= lsb_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            alu_hd_q    <= '0;
            alu_tl_q    <= '0;
            alu_cnt_q   <= '0;
            lsb_hd_q    <= '0;
            lsb_tl_q    <= '0;
            lsb_cnt_q   <= '0;
            last_lsb_q  <= 1'b1;
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_data_q  <= '0;
            cdb_jmp_q   <= 1'b0;
        end else begin
            alu_hd_q    <= alu_hd_d;
            alu_tl_q    <= alu_tl_d;
            alu_cnt_q   <= alu_cnt_d;
            lsb_hd_q    <= lsb_hd_d;
            lsb_tl_q    <= lsb_tl_d;
            lsb_cnt_q   <= lsb_cnt_d;
            last_lsb_q  <= last_lsb_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_data_q  <= cdb_data_d;
            cdb_jmp_q   <= cdb_jmp_d;
        end
    end

    assign cdb_valid         = cdb_valid_q;
    assign cdb_rob_id        = cdb_rob_q;
    assign cdb_data          = cdb_data_q;
    assign cdb_set_jump_addr = cdb_jmp_q;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: entries per source queue, power of two, at least 2.
REQ-002 SHALL have parameter ROB_W, default `ROB_WIDTH: rob id width.
REQ-003 SHALL have port clk_in, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in, input, 1: global enable; low freezes all state.
REQ-006 SHALL have port flush, input, 1: mispredict flush, sampled only when rdy_in=1.
REQ-007 SHALL have port alu_valid, input, 1: ALU result offered.
REQ-008 SHALL have port alu_ready, output, 1: ALU queue can accept.
REQ-009 SHALL have port alu_rob_id, input, ROB_W: ALU result tag.
REQ-010 SHALL have port alu_data, input, 32: ALU result value.
REQ-011 SHALL have port alu_set_jump_addr, input, 1: ALU result is a jump target.
REQ-012 SHALL have port lsb_valid, input, 1: LSB result offered.
REQ-013 SHALL have port lsb_ready, output, 1: LSB queue can accept.
REQ-014 SHALL have port lsb_rob_id, input, ROB_W: LSB result tag.
REQ-015 SHALL have port lsb_data, input, 32: LSB result value.
REQ-016 SHALL have port cdb_valid, output, 1: broadcast valid this cycle.
REQ-017 SHALL have port cdb_rob_id, output, ROB_W: broadcast tag.
REQ-018 SHALL have port cdb_data, output, 32: broadcast value.
REQ-019 SHALL have port cdb_set_jump_addr, output, 1: broadcast is a jump target; always 0 for LSB-sourced entries.

Function
REQ-020 SHALL keep one FIFO per source (ALU, LSB), FIFO_DEPTH entries each, with head/tail pointers wrapping modulo FIFO_DEPTH and an occupancy count 0..FIFO_DEPTH.
REQ-021 SHALL drive alu_ready/lsb_ready = (count < FIFO_DEPTH), decoded from registered count only, with no combinational path from any input.
REQ-022 SHALL push a source entry on an edge where rdy_in=1, flush=0, valid=1 and ready=1; valid while ready=0 is ignored, and the producer holds.
REQ-023 SHALL pop at most one entry in total per edge, and only when rdy_in=1 and flush=0.
REQ-024 SHALL grant as follows: only one FIFO non-empty -> that FIFO; both non-empty -> the source not granted last (round-robin bit last_grant); both empty -> no pop.
REQ-025 SHALL on a grant load the popped head into cdb_* registers with cdb_valid=1, and update last_grant to the granted source.
REQ-026 SHALL on an edge with rdy_in=1 and no grant set cdb_valid=0; cdb_rob_id, cdb_data and cdb_set_jump_addr keep their values.
REQ-027 SHALL produce latency of exactly one edge from push to earliest broadcast: push at edge E, pop at edge E+1 at earliest, cdb_valid high after E+1; no bypass.
REQ-028 SHALL allow push and pop of the same FIFO on one edge when not full (count unchanged); a full FIFO rejects push even if popping that edge.
REQ-029 SHALL while rdy_in=0 hold FIFOs, counts, last_grant and all cdb_* outputs unchanged.
REQ-030 SHALL on an edge with rdy_in=1 and flush=1 empty both FIFOs (count=0, pointers=0), set cdb_valid=0 and last_grant=LSB, and discard same-edge pushes.
REQ-031 SHALL never drop, duplicate or reorder entries within a source; cross-source order is defined solely by REQ-024.

Reset
REQ-032 SHALL on rst_n_in=0, asynchronously: cdb_valid=0, cdb_rob_id=0, cdb_data=0, cdb_set_jump_addr=0, both counts and pointers 0, last_grant=LSB (first contested grant goes to ALU), alu_ready=lsb_ready=1.
REQ-033 SHALL on assertion mid-operation lose all queued entries, and SHALL begin accepting pushes on the first rising edge after deassertion.

Verification
REQ-034 SHALL cover a single ALU push (rob 3, data 0x1234, jump=1) -> after next edge cdb_valid=1, rob 3, 0x1234, jump=1; following edge cdb_valid=0.
REQ-035 SHALL cover ALU and LSB each pushing 2 entries on the same edges (A0,A1 / L0,L1) -> broadcast order A0, L0, A1, L1 on 4 consecutive cycles.
REQ-036 SHALL cover LSB filling to 2 while ALU stalls the bus -> lsb_ready=0; next lsb_valid held until a pop, then accepted; no loss.
REQ-037 SHALL cover rdy_in=0 for 3 cycles with cdb_valid=1 (rob 5) -> outputs, counts and ready flags unchanged, resuming exactly where stopped.
REQ-038 SHALL cover flush=1 with both FIFOs holding 2 entries plus simultaneous alu_valid -> next cycle cdb_valid=0, both ready=1, no old entry ever broadcast.
REQ-039 SHALL cover rst_n_in pulsed low between edges with queued data -> cdb_valid=0 immediately, before any clock edge.
